io_port_bank: RTL and testbench

Parametrised memory-mapped I/O port bank for the 8-bit computer. It replaces the fixed 16-in/16-out port wiring with NUM_PORTS input and output ports of DATA_W bits, all on the CPU load/store bus. New over the fixed ports:
- 2-flop input synchronisers
- output write strobes and output readback
- per-port input change-detect flags with maskable interrupt

---
 rtl/io_port_bank.sv | 174 +++++++++++++++++
 tb/tb_io_port_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of NUM_PORTS input and NUM_PORTS output ports of
// DATA_W bits on the CPU load/store bus.
//
// Features:
//   - 2-flop synchroniser on every input port
//   - output write strobes and output readback
//   - per-port change-detect pending flags with a maskable interrupt
//
// Address map (full ADDR_W compare, priority OUT > IN > CTRL):
//   OUT_BASE  + i : output port i (read returns the current output value)
//   IN_BASE   + i : input port i, synchronised (read only)
//   CTRL_BASE + k : pending flags for ports [k*DATA_W +: DATA_W], write 1 to clear
//   CTRL_BASE+8+k : interrupt mask for the same ports
//   anything else : reads return 0, writes are ignored
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   addr_i            bus address
//   wdata_i, we_i     write data and write enable
//   re_i              read enable
//   rdata_o, rvalid_o registered read data, valid for one cycle, one cycle after re_i
//   port_in_i         asynchronous inputs, port i at [i*DATA_W +: DATA_W]
//   port_out_o        registered outputs, same packing
//   out_strobe_o      one-cycle pulse per port, aligned with its new output value
//   irq_o             registered OR of (pending & mask)
module io_port_bank #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       NUM_PORTS = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE  = 8'hE0,
  parameter logic [ADDR_W-1:0] IN_BASE   = 8'hF0,
  parameter logic [ADDR_W-1:0] CTRL_BASE = 8'hD0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        we_i,
  input  logic                        re_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        rvalid_o,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in_i,
  output logic [NUM_PORTS*DATA_W-1:0] port_out_o,
  output logic [NUM_PORTS-1:0]        out_strobe_o,
  output logic                        irq_o
);

  localparam int unsigned FB = (NUM_PORTS + DATA_W - 1) / DATA_W;
  localparam int unsigned PW = FB * DATA_W;
  localparam int unsigned NB = NUM_PORTS * DATA_W;

  localparam logic [ADDR_W-1:0] NumPortsA = ADDR_W'(NUM_PORTS);
  localparam logic [ADDR_W-1:0] FbA       = ADDR_W'(FB);
  localparam logic [ADDR_W-1:0] MaskOffA  = ADDR_W'(8);

  logic [NB-1:0]       port_out_q, port_out_d;
  logic [NUM_PORTS-1:0] strobe_q, strobe_d;
  logic [NB-1:0]       s1_q, s2_q, prev_q, prev_d;
  logic [PW-1:0]       pend_q, pend_d, mask_q, mask_d;
  logic [1:0]          settle_q, settle_d;
  logic [DATA_W-1:0]   rdata_q, rd_val;
  logic                rvalid_q, irq_q;

  // Address decode
  logic [ADDR_W-1:0] out_off, in_off, ctl_off, msk_off;
  logic              out_hit, in_hit, pnd_hit, msk_hit;

  assign out_off = addr_i - OUT_BASE;
  assign in_off  = addr_i - IN_BASE;
  assign ctl_off = addr_i - CTRL_BASE;
  assign msk_off = ctl_off - MaskOffA;

  assign out_hit = (out_off < NumPortsA);
  assign in_hit  = !out_hit && (in_off < NumPortsA);
  assign pnd_hit = !out_hit && !in_hit && (ctl_off < FbA);
  assign msk_hit = !out_hit && !in_hit && (ctl_off >= MaskOffA) && (msk_off < FbA);

  // Flag bits that correspond to real ports; padding bits stay zero.
  logic [PW-1:0] valid_m;
  logic [PW-1:0] chg;
  always_comb begin
    valid_m = '0;
    chg     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_m[i] = 1'b1;
      chg[i]     = (s2_q[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
    end
  end

  logic          settling;
  logic [PW-1:0] pnd_clr;
  assign settling = (settle_q != 2'd0);

  always_comb begin
    port_out_d = port_out_q;
    strobe_d   = '0;
    mask_d     = mask_q;
    pnd_clr    = '0;
    if (we_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (out_hit && out_off == ADDR_W'(i)) begin
          port_out_d[i*DATA_W +: DATA_W] = wdata_i;
          strobe_d[i]                    = 1'b1;
        end
      end
      for (int k = 0; k < FB; k++) begin
        if (pnd_hit && ctl_off == ADDR_W'(k)) pnd_clr[k*DATA_W +: DATA_W] = wdata_i;
        if (msk_hit && msk_off == ADDR_W'(k)) mask_d[k*DATA_W +: DATA_W] = wdata_i;
      end
    end
    mask_d = mask_d & valid_m;

    // A new change on the same edge as a clear wins.
    pend_d = (pend_q & ~pnd_clr) | (settling ? '0 : chg);

    // While settling, prev follows the value s2 takes at this edge so that the first
    // enabled compare sees no difference for inputs that were static through reset.
    prev_d   = settling ? s1_q : s2_q;
    settle_d = settling ? settle_q - 2'd1 : settle_q;
  end

  // Read mux; uses pre-edge state so a same-cycle write is not visible yet.
  always_comb begin
    rd_val = '0;
    if (out_hit) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (out_off == ADDR_W'(i)) rd_val = port_out_q[i*DATA_W +: DATA_W];
    end else if (in_hit) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (in_off == ADDR_W'(i)) rd_val = s2_q[i*DATA_W +: DATA_W];
    end else if (pnd_hit) begin
      for (int k = 0; k < FB; k++)
        if (ctl_off == ADDR_W'(k)) rd_val = pend_q[k*DATA_W +: DATA_W];
    end else if (msk_hit) begin
      for (int k = 0; k < FB; k++)
        if (msk_off == ADDR_W'(k)) rd_val = mask_q[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      port_out_q <= '0;
      strobe_q   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      settle_q   <= 2'd2;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      strobe_q   <= strobe_d;
      s1_q       <= port_in_i;
      s2_q       <= s1_q;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      settle_q   <= settle_d;
      rvalid_q   <= re_i;
      if (re_i) rdata_q <= rd_val;
      irq_q      <= |(pend_q & mask_q);
    end
  end

  assign port_out_o   = port_out_q;
  assign out_strobe_o = strobe_q;
  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   addr, wdata, rdata;
  logic         we, re, rvalid, irq;
  logic [127:0] port_in, port_out;
  logic [15:0]  out_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .we_i        (we),
    .re_i        (re),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .port_in_i   (port_in),
    .port_out_o  (port_out),
    .out_strobe_o(out_strobe),
    .irq_o       (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    port_in = '0; port_in[7:0] = 8'hF3;
    tick(); tick();
    checks++; if (port_out !== 128'h0) begin errors++;
      $display("FAIL reset_port_out got %h exp 0", port_out); end
    checks++; if (out_strobe !== 16'h0) begin errors++;
      $display("FAIL reset_strobe got %h exp 0", out_strobe); end
    checks++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin errors++;
      $display("FAIL reset_read got rvalid %b rdata %h exp 0 00", rvalid, rdata); end
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL reset_irq got %b exp 0", irq); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (irq !== 1'b0) begin errors++;
        $display("FAIL settle_irq cycle %0d got %b exp 0", c, irq); end
    end
    bus_read(8'hD0);
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++;
      $display("FAIL settle_pending got %h/%b exp 00/1", rdata, rvalid); end
    bus_read(8'hF0);
    checks++; if (rdata !== 8'hF3 || rvalid !== 1'b1) begin errors++;
      $display("FAIL in_read got %h/%b exp f3/1", rdata, rvalid); end
    tick();
    checks++; if (rvalid !== 1'b0 || rdata !== 8'hF3) begin errors++;
      $display("FAIL rdata_hold got %h/%b exp f3/0", rdata, rvalid); end
  endtask

  task automatic test_write_strobe();
    bus_write(8'hE3, 8'h5A);
    checks++; if (port_out !== {96'h0, 8'h5A, 24'h0}) begin errors++;
      $display("FAIL write_port_out got %h", port_out); end
    checks++; if (out_strobe !== 16'h0008) begin errors++;
      $display("FAIL write_strobe got %h exp 0008", out_strobe); end
    tick();
    checks++; if (out_strobe !== 16'h0000) begin errors++;
      $display("FAIL strobe_len got %h exp 0000", out_strobe); end
    bus_read(8'hE3);
    checks++; if (rdata !== 8'h5A || rvalid !== 1'b1) begin errors++;
      $display("FAIL readback got %h/%b exp 5a/1", rdata, rvalid); end
    bus_write(8'hF3, 8'hFF);
    checks++; if (port_out !== {96'h0, 8'h5A, 24'h0} || out_strobe !== 16'h0) begin errors++;
      $display("FAIL in_write_ignored got %h/%h", port_out, out_strobe); end
    bus_write(8'hE3, 8'h5A);
    checks++; if (out_strobe !== 16'h0008) begin errors++;
      $display("FAIL same_value_strobe got %h exp 0008", out_strobe); end
  endtask

  task automatic test_change_irq();
    bus_write(8'hD8, 8'h06);
    port_in[15:8] = 8'h0D; port_in[23:16] = 8'h0F;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL irq_early_e1 got %b exp 0", irq); end
    addr = 8'hD0; re = 1'b1;
    tick();
    checks++; if (rdata !== 8'h00 || irq !== 1'b0) begin errors++;
      $display("FAIL pending_before_e2 got %h/%b exp 00/0", rdata, irq); end
    tick();
    re = 1'b0;
    checks++; if (rdata !== 8'h06) begin errors++;
      $display("FAIL pending_at_e2 got %h exp 06", rdata); end
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL irq_at_e3 got %b exp 1", irq); end
    bus_write(8'hD0, 8'h02);
    tick();
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL irq_partial_clear got %b exp 1", irq); end
    bus_read(8'hD0);
    checks++; if (rdata !== 8'h04) begin errors++;
      $display("FAIL pending_after_clear got %h exp 04", rdata); end
    bus_write(8'hD0, 8'h04);
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL irq_clear_edge got %b exp 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL irq_drop got %b exp 0", irq); end
    bus_read(8'hD8);
    checks++; if (rdata !== 8'h06) begin errors++;
      $display("FAIL mask_readback got %h exp 06", rdata); end
  endtask

  task automatic test_set_wins();
    addr = 8'hD0; wdata = 8'h20;
    for (int j = 0; j < 10; j++) begin
      port_in[40] = ~port_in[40];
      we = (j == 5);
      re = (j == 6);
      tick();
      if (j == 6) begin
        checks++; if (rdata !== 8'h20 || rvalid !== 1'b1) begin errors++;
          $display("FAIL set_wins got %h/%b exp 20/1", rdata, rvalid); end
      end
    end
    we = 1'b0; re = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL unmasked_irq got %b exp 0", irq); end
    tick(); tick(); tick(); tick();
    bus_write(8'hD0, 8'h20);
    bus_read(8'hD0);
    checks++; if (rdata !== 8'h00) begin errors++;
      $display("FAIL quiet_clear got %h exp 00", rdata); end
  endtask

  task automatic test_same_cycle_rw();
    bus_write(8'hE0, 8'h11);
    addr = 8'hE0; wdata = 8'h22; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    checks++; if (rdata !== 8'h11 || rvalid !== 1'b1) begin errors++;
      $display("FAIL rw_old_value got %h/%b exp 11/1", rdata, rvalid); end
    checks++; if (port_out[7:0] !== 8'h22 || out_strobe !== 16'h0001) begin errors++;
      $display("FAIL rw_write got %h/%h exp 22/0001", port_out[7:0], out_strobe); end
    bus_read(8'h00);
    checks++; if (rdata !== 8'h00 || rvalid !== 1'b1) begin errors++;
      $display("FAIL unmapped_read got %h/%b exp 00/1", rdata, rvalid); end
  endtask

  task automatic test_reset_midop();
    port_in[31:24] = 8'h01;
    tick(); tick(); tick(); tick();
    bus_read(8'hD0);
    checks++; if (rdata !== 8'h08) begin errors++;
      $display("FAIL port3_pending got %h exp 08", rdata); end
    bus_write(8'hD8, 8'h08);
    tick();
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL port3_irq got %b exp 1", irq); end
    bus_write(8'hE7, 8'h77);
    checks++; if (out_strobe !== 16'h0080) begin errors++;
      $display("FAIL e7_strobe got %h exp 0080", out_strobe); end
    rst = 1'b1;
    tick();
    checks++; if (out_strobe !== 16'h0 || port_out !== 128'h0) begin errors++;
      $display("FAIL midop_reset_out got %h/%h exp 0/0", out_strobe, port_out); end
    checks++; if (irq !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'h00) begin errors++;
      $display("FAIL midop_reset_misc got %b/%b/%h exp 0/0/00", irq, rvalid, rdata); end
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    bus_read(8'hD0);
    checks++; if (rdata !== 8'h00) begin errors++;
      $display("FAIL midop_pending got %h exp 00", rdata); end
    bus_read(8'hD8);
    checks++; if (rdata !== 8'h00) begin errors++;
      $display("FAIL midop_mask got %h exp 00", rdata); end
  endtask

  initial begin
    test_reset();
    test_write_strobe();
    test_change_irq();
    test_set_wins();
    test_same_cycle_rw();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
